// File: rtl/rtc0_apb_arb.sv
// rtc0_apb_arb: two-port round-robin APB arbiter with rtc0 trust gate.
// Define RTC0_APB_ARB_SLVERR_EN to flag blocked accesses with pslverr.
module rtc0_apb_arb #(
    parameter int ADDR_W = 32
) (
    input  logic              aortc_pclk,
    input  logic              aortc_rst,
    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic              s0_pwrite,
    input  logic [ADDR_W-1:0] s0_paddr,
    input  logic [31:0]       s0_pwdata,
    input  logic [2:0]        s0_pprot,
    output logic [31:0]       s0_prdata,
    output logic              s0_pready,
    output logic              s0_pslverr,
    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic              s1_pwrite,
    input  logic [ADDR_W-1:0] s1_paddr,
    input  logic [31:0]       s1_pwdata,
    input  logic [2:0]        s1_pprot,
    output logic [31:0]       s1_prdata,
    output logic              s1_pready,
    output logic              s1_pslverr,
    input  logic              tipc_rtc0_trust,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [31:0]       m_pwdata,
    output logic [2:0]        m_pprot,
    input  logic [31:0]       m_prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

`ifdef RTC0_APB_ARB_SLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              m_psel_q, m_psel_d;
    logic              m_penable_q, m_penable_d;
    logic              m_pwrite_q, m_pwrite_d;
    logic [ADDR_W-1:0] m_paddr_q, m_paddr_d;
    logic [31:0]       m_pwdata_q, m_pwdata_d;
    logic [2:0]        m_pprot_q, m_pprot_d;
    logic [1:0]        rdy_q, rdy_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       rd0_q, rd0_d;
    logic [31:0]       rd1_q, rd1_d;

    logic       pick;
    logic [2:0] w_prot;
    logic       blk;
    logic       unused_penable;

    // penable only qualifies the upstream protocol; requests are psel-based
    assign unused_penable = s0_penable ^ s1_penable;

    // on a tie the port that did not win last time gets the bus
    assign pick   = (s0_psel & s1_psel) ? ~last_q : s1_psel;
    assign w_prot = pick ? s1_pprot : s0_pprot;
    assign blk    = tipc_rtc0_trust & w_prot[1];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        m_psel_d    = 1'b0;
        m_penable_d = 1'b0;
        m_pwrite_d  = m_pwrite_q;
        m_paddr_d   = m_paddr_q;
        m_pwdata_d  = m_pwdata_q;
        m_pprot_d   = m_pprot_q;
        rdy_d       = 2'b00;
        err_d       = 2'b00;
        rd0_d       = 32'h0;
        rd1_d       = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (s0_psel | s1_psel) begin
                    last_d = pick;
                    gnt_d  = pick;
                    if (blk) begin
                        state_d     = RESP;
                        rdy_d[pick] = 1'b1;
                        err_d[pick] = ERR_EN;
                    end else begin
                        state_d    = SETUP;
                        m_psel_d   = 1'b1;
                        m_pwrite_d = pick ? s1_pwrite : s0_pwrite;
                        m_paddr_d  = pick ? s1_paddr : s0_paddr;
                        m_pwdata_d = pick ? s1_pwdata : s0_pwdata;
                        m_pprot_d  = w_prot;
                    end
                end
            end
            SETUP: begin
                m_psel_d    = 1'b1;
                m_penable_d = 1'b1;
                state_d     = ACCESS;
            end
            ACCESS: begin
                state_d      = RESP;
                rdy_d[gnt_q] = 1'b1;
                if (!m_pwrite_q) begin
                    if (gnt_q) rd1_d = m_prdata;
                    else       rd0_d = m_prdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aortc_pclk) begin
        if (aortc_rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= 32'h0;
            m_pprot_q   <= 3'b000;
            rdy_q       <= 2'b00;
            err_q       <= 2'b00;
            rd0_q       <= 32'h0;
            rd1_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_pwrite_q  <= m_pwrite_d;
            m_paddr_q   <= m_paddr_d;
            m_pwdata_q  <= m_pwdata_d;
            m_pprot_q   <= m_pprot_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
        end
    end

    assign m_psel     = m_psel_q;
    assign m_penable  = m_penable_q;
    assign m_pwrite   = m_pwrite_q;
    assign m_paddr    = m_paddr_q;
    assign m_pwdata   = m_pwdata_q;
    assign m_pprot    = m_pprot_q;
    assign s0_pready  = rdy_q[0];
    assign s1_pready  = rdy_q[1];
    assign s0_pslverr = err_q[0];
    assign s1_pslverr = err_q[1];
    assign s0_prdata  = rd0_q;
    assign s1_prdata  = rd1_q;

endmodule

// File: tb/tb_rtc0_apb_arb.sv
// tb_rtc0_apb_arb: directed bench for rtc0_apb_arb with a timeline model
// of each granted transfer, checked every cycle on the falling edge.
module tb_rtc0_apb_arb;
    localparam int AW = 32;
`ifdef RTC0_APB_ARB_SLVERR_EN
    localparam logic SLV = 1'b1;
`else
    localparam logic SLV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trust = 1'b0;
    logic [1:0] psel = '0, penable = '0, pwrite = '0;
    logic [1:0][AW-1:0] paddr = '0;
    logic [1:0][31:0] pwdata = '0;
    logic [1:0][2:0] pprot = '0;
    logic [1:0][31:0] prdata;
    logic [1:0] pready, pslverr;
    logic m_psel, m_penable, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [2:0] m_pprot;
    logic [31:0] m_prdata = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rtc0_apb_arb #(.ADDR_W(AW)) dut (
        .aortc_pclk(clk), .aortc_rst(rst),
        .s0_psel(psel[0]), .s0_penable(penable[0]), .s0_pwrite(pwrite[0]),
        .s0_paddr(paddr[0]), .s0_pwdata(pwdata[0]), .s0_pprot(pprot[0]),
        .s0_prdata(prdata[0]), .s0_pready(pready[0]), .s0_pslverr(pslverr[0]),
        .s1_psel(psel[1]), .s1_penable(penable[1]), .s1_pwrite(pwrite[1]),
        .s1_paddr(paddr[1]), .s1_pwdata(pwdata[1]), .s1_pprot(pprot[1]),
        .s1_prdata(prdata[1]), .s1_pready(pready[1]), .s1_pslverr(pslverr[1]),
        .tipc_rtc0_trust(trust),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pprot(m_pprot),
        .m_prdata(m_prdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a transfer granted at edge ge is described by its offset.
    // Allowed: +0 setup, +1 access, +2 response, +3 idle again.
    // Blocked: +0 response, +1 idle again.
    int n = 0;
    int ge = 0;
    int off = 0;
    bit chk_en = 0;
    bit busy = 0, blk = 0, lastg = 1, gp = 0, gw = 0;
    logic [31:0] rdv = 0;
    logic e_psel = 0, e_pen = 0, e_pw = 0;
    logic [AW-1:0] e_addr = 0;
    logic [31:0] e_wd = 0;
    logic [2:0] e_prot = 0;
    logic [1:0] e_rdy = 0, e_err = 0;
    logic [1:0][31:0] e_rd = 0;

    initial forever begin
        @(posedge clk);
        n++;
        if (rst) begin
            busy = 0; lastg = 1; chk_en = 1;
            e_pw = 0; e_addr = 0; e_wd = 0; e_prot = 0; rdv = 0;
        end else if (busy) begin
            off = n - ge;
            if (!blk && off == 2) rdv = gw ? 32'h0 : m_prdata;
            if ((blk && off == 1) || (!blk && off == 3)) busy = 0;
        end else if (psel != 2'b00) begin
            gp = (psel == 2'b11) ? !lastg : psel[1];
            lastg = gp; busy = 1; ge = n; gw = pwrite[gp];
            blk = trust && pprot[gp][1];
            if (!blk) begin
                e_pw = pwrite[gp]; e_addr = paddr[gp];
                e_wd = pwdata[gp]; e_prot = pprot[gp];
            end
        end
        e_psel = 0; e_pen = 0; e_rdy = 0; e_err = 0; e_rd = '0;
        if (busy) begin
            off = n - ge;
            if (blk) begin
                e_rdy[gp] = 1; e_err[gp] = SLV;
            end else if (off == 0) begin
                e_psel = 1;
            end else if (off == 1) begin
                e_psel = 1; e_pen = 1;
            end else begin
                e_rdy[gp] = 1; e_rd[gp] = rdv;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_psel", 64'(m_psel), 64'(e_psel));
            chk("m_penable", 64'(m_penable), 64'(e_pen));
            chk("m_pwrite", 64'(m_pwrite), 64'(e_pw));
            chk("m_paddr", 64'(m_paddr), 64'(e_addr));
            chk("m_pwdata", 64'(m_pwdata), 64'(e_wd));
            chk("m_pprot", 64'(m_pprot), 64'(e_prot));
            chk("pready", 64'(pready), 64'(e_rdy));
            chk("pslverr", 64'(pslverr), 64'(e_err));
            chk("s0_prdata", 64'(prdata[0]), 64'(e_rd[0]));
            chk("s1_prdata", 64'(prdata[1]), 64'(e_rd[1]));
        end
    end

    logic [AW-1:0] alog[$];
    int plog[$];
    int clog[$];

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_psel && !m_penable) alog.push_back(m_paddr);
        for (int p = 0; p < 2; p++)
            if (pready[p]) begin plog.push_back(p); clog.push_back(n); end
    endtask

    task automatic xfer(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] pr, input int lat,
                        input logic [31:0] erd, input logic eerr, input string nm);
        int k;
        bit got;
        pwrite[p] = w; paddr[p] = a; pwdata[p] = d; pprot[p] = pr; psel[p] = 1'b1;
        k = 0; got = 0;
        while (!got && k < 12) begin
            tick(); k++; got = pready[p];
        end
        chk({nm, "_lat"}, 64'(k), 64'(lat));
        chk({nm, "_rdata"}, 64'(prdata[p]), 64'(erd));
        chk({nm, "_err"}, 64'(pslverr[p]), 64'(eerr));
        psel[p] = 1'b0;
        tick();
    endtask

    initial begin
        int k, cnt, na;
        bit got;
        repeat (3) tick();
        chk("rst_psel", 64'(m_psel), 64'h0);
        chk("rst_pready", 64'(pready), 64'h0);
        chk("rst_paddr", 64'(m_paddr), 64'h0);
        rst = 0;
        tick();

        m_prdata = 32'h1234_5678;
        xfer(0, 1'b0, 32'h04, 32'h0, 3'b000, 3, 32'h1234_5678, 1'b0, "rd0");
        chk("rd0_addr", 64'(alog[alog.size()-1]), 64'h04);

        trust = 1;
        na = alog.size();
        xfer(1, 1'b1, 32'h10, 32'hCC, 3'b010, 1, 32'h0, SLV, "blk");
        chk("blk_nopsel", 64'(alog.size()), 64'(na));
        xfer(1, 1'b1, 32'h10, 32'hCC, 3'b000, 3, 32'h0, 1'b0, "sec");
        chk("sec_addr", 64'(alog[alog.size()-1]), 64'h10);
        trust = 0;

        // abort a read during its access phase
        plog.delete();
        pwrite[0] = 0; paddr[0] = 32'h20; pprot[0] = 3'b000; psel[0] = 1;
        tick();
        tick();
        chk("mid_pen", 64'(m_penable), 64'h1);
        rst = 1;
        tick();
        chk("mid_psel", 64'(m_psel), 64'h0);
        chk("mid_pen0", 64'(m_penable), 64'h0);
        chk("mid_paddr", 64'(m_paddr), 64'h0);
        psel[0] = 0;
        tick();
        rst = 0;
        tick();
        tick();
        chk("mid_nordy", 64'(plog.size()), 64'h0);

        alog.delete(); plog.delete(); clog.delete();
        pwrite = 2'b11;
        paddr[0] = 32'h08; pwdata[0] = 32'hAA; pprot[0] = 3'b000;
        paddr[1] = 32'h0C; pwdata[1] = 32'hBB; pprot[1] = 3'b000;
        psel = 2'b11;
        k = 0;
        while (psel != 2'b00 && k < 20) begin
            tick(); k++;
            for (int p = 0; p < 2; p++) if (pready[p]) psel[p] = 1'b0;
        end
        tick();
        chk("cont_n", 64'(alog.size()), 64'h2);
        chk("cont_nr", 64'(plog.size()), 64'h2);
        if (alog.size() >= 2 && plog.size() >= 2) begin
            chk("cont_a0", 64'(alog[0]), 64'h08);
            chk("cont_a1", 64'(alog[1]), 64'h0C);
            chk("cont_p0", 64'(plog[0]), 64'h0);
            chk("cont_p1", 64'(plog[1]), 64'h1);
            chk("cont_gap", 64'(clog[1] - clog[0]), 64'h4);
        end

        plog.delete();
        psel = 2'b11;
        repeat (17) tick();
        psel = 2'b00;
        repeat (5) tick();
        chk("alt_n", 64'(plog.size() >= 4), 64'h1);
        if (plog.size() >= 4)
            for (int i = 0; i < 4; i++) chk("alt_port", 64'(plog[i]), 64'(i % 2));

        // requester walks away after the grant
        m_prdata = 32'hCAFE_F00D;
        pwrite[1] = 0; paddr[1] = 32'h30; pprot[1] = 3'b000; psel[1] = 1;
        tick();
        psel[1] = 0;
        tick();
        chk("abd_pen", 64'(m_penable), 64'h1);
        cnt = 0;
        repeat (6) begin
            tick();
            if (pready[1]) begin
                cnt++;
                chk("abd_rdata", 64'(prdata[1]), 64'hCAFE_F00D);
            end
        end
        chk("abd_pulses", 64'(cnt), 64'h1);

        // trust only matters at grant time
        m_prdata = 32'h0BAD_BEEF;
        pwrite[1] = 0; paddr[1] = 32'h34; pprot[1] = 3'b010; psel[1] = 1;
        tick();
        trust = 1;
        k = 1; got = pready[1];
        while (!got && k < 12) begin
            tick(); k++; got = pready[1];
        end
        chk("tchg_lat", 64'(k), 64'h3);
        chk("tchg_rdata", 64'(prdata[1]), 64'h0BAD_BEEF);
        chk("tchg_err", 64'(pslverr[1]), 64'h0);
        psel[1] = 0;
        trust = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rtc0_apb_arb.md
Name: rtc0_apb_arb

Overview:
- Two-port APB arbiter in front of the rtc0 APB slave.
- Shares the single RTC register port between a secure requester (port 0, e.g. CPU) and a second requester (port 1, e.g. DMA/debug), using round-robin grant.
- Enforces the rtc0 trust gate: non-secure accesses are blocked when the RTC is marked trusted.
- Turns the RTC's zero-wait APB into a stallable APB with pready/pslverr per upstream port.

Parameters:
- ADDR_W, 32, width of paddr on all ports.

Ports:
- aortc_pclk  in  1  APB clock.
- aortc_rst  in  1  reset; synchronous, active-high.
- sN_psel  in  1  port N select (N = 0, 1; all sN_ signals repeat for both ports).
- sN_penable  in  1  port N enable.
- sN_pwrite  in  1  port N write.
- sN_paddr  in  ADDR_W  port N address.
- sN_pwdata  in  32  port N write data.
- sN_pprot  in  3  port N protection; bit1 = 1 means non-secure.
- sN_prdata  out  32  port N read data, valid while sN_pready = 1.
- sN_pready  out  1  port N transfer complete.
- sN_pslverr  out  1  port N error.
- tipc_rtc0_trust  in  1  1 = rtc0 is secure-only.
- m_psel  out  1  to RTC.
- m_penable  out  1  to RTC.
- m_pwrite  out  1  to RTC.
- m_paddr  out  ADDR_W  to RTC.
- m_pwdata  out  32  to RTC.
- m_pprot  out  3  to RTC.
- m_prdata  in  32  from RTC; RTC is always ready.

Behaviour:
- Clock/reset: single clock aortc_pclk. Reset aortc_rst is synchronous and active-high.
- Reset values:
  - All outputs 0; state IDLE; last_grant = 1, so port 0 wins the first tie.
  - Reset asserted mid-transfer aborts it: outputs are 0 on the next edge and no pready is given.
- Request: req_N = sN_psel. sN_penable is not used for arbitration. The requester holds all signals until sN_pready.
- FSM, all outputs registered:
  - IDLE: no request -> IDLE.
    - One request -> grant it.
    - Both requesting -> grant the port != last_grant.
    - On grant: latch pwrite/paddr/pwdata/pprot of the winner; update last_grant.
    - If blocked (tipc_rtc0_trust = 1 and latched pprot[1] = 1) -> RESP. Otherwise -> SETUP.
  - SETUP: m_psel = 1, m_penable = 0, m_* = latched values -> ACCESS.
  - ACCESS: m_psel = 1, m_penable = 1. Capture m_prdata into rdata_q; zero for writes -> RESP.
  - RESP: m_psel = m_penable = 0.
    - Granted port: sN_pready = 1 for exactly one cycle; sN_prdata = rdata_q.
    - Blocked access: prdata = 0; pslverr per the optional feature.
    - -> IDLE.
- Latency:
  - Request sampled in IDLE at cycle t -> SETUP t+1, ACCESS t+2, pready t+3.
  - Blocked access: pready at t+1.
  - Minimum 4 cycles per allowed transfer; a new grant is only taken in IDLE.
- Non-granted port: pready = 0, prdata = 0, pslverr = 0 throughout.
- Requester drops psel before RESP: the downstream transfer still completes and the pready pulse is still issued. No retry.
- tipc_rtc0_trust is sampled only at grant; later changes do not affect the transfer in flight.
- Blocked writes never reach the RTC: m_psel stays 0.
- m_pwdata/m_paddr/m_pprot hold their last values in IDLE; only m_psel/m_penable return to 0.

Optional Feature:
- Macro: RTC0_APB_ARB_SLVERR_EN.
- Defined: a blocked access returns sN_pslverr = 1 in RESP alongside pready.
- Undefined: sN_pslverr is tied 0. Blocked reads return 0 and blocked writes are silently dropped. Timing is identical in both builds.

Test Plan:
- Single read: s0 reads 0x04, m_prdata = 0x1234_5678, trust = 0 -> m_psel at t+1, m_penable at t+2, s0_pready pulse at t+3 with s0_prdata = 0x1234_5678, s0_pslverr = 0.
- Contention:
  - s0 and s1 both raise psel with writes 0xAA to 0x08 and 0xBB to 0x0C -> s0 served first, then s1.
  - m_paddr sequence 0x08, 0x0C; each pready arrives 4 cycles apart.
  - Hold both requesting continuously -> grants alternate 0, 1, 0, 1.
- Trust block:
  - trust = 1, s1 write 0x10 with pprot = 3'b010 -> m_psel never asserts; s1_pready at t+1.
  - s1_pslverr = 1 with the macro defined, 0 without.
  - Same access with pprot = 3'b000 -> passes through normally.
- Reset mid-op: assert aortc_rst during ACCESS -> all outputs 0 on the next edge, no pready. After release, simultaneous requests grant s0 first.
- Abandoned request: s1 drops psel in SETUP -> ACCESS still issued, s1_pready pulses once, FSM returns to IDLE.
- Trust change in flight: trust toggles 0 -> 1 during SETUP of a non-secure read -> transfer completes normally, pslverr = 0.
